morse_tx_sequencer: RTL

Sequencer that turns 3-bit letter codes into timed Morse on-off keying on a single output. It accepts a code over a valid/ready handshake, looks up the 13-bit element pattern, and shifts it out LSB-first at one bit per unit time. Each letter is followed by an inter-letter gap, then a one-cycle `done` pulse. It replaces the free-running divider/shifter pair with a controlled datapath that upstream logic (switch debouncer, UART, test FSM) can drive letter by letter.

---
 rtl/morse_tx_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/morse_tx_sequencer.sv
// morse_tx_sequencer: handshake-driven Morse on-off keying, LSB-first patterns.
// Define MORSE_QUEUE_EN to add a one-entry request buffer.
module morse_tx_sequencer #(
  parameter int TICKS_PER_UNIT = 25_000_000,
  parameter int GAP_UNITS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_code,
  output logic       req_ready,
  output logic       morse_out,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(TICKS_PER_UNIT);
  localparam int GW = $clog2(GAP_UNITS + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(TICKS_PER_UNIT - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(GAP_UNITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        r_state, w_state;
  logic [12:0]   r_sh, w_sh;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [GW-1:0] r_gcnt, w_gcnt;
  logic          r_done, w_done;
  logic          w_accept;
`ifdef MORSE_QUEUE_EN
  logic [2:0]    r_buf_code, w_buf_code;
  logic          r_buf_full, w_buf_full;
  logic          w_take;
`endif

  function automatic logic [12:0] rom(input logic [2:0] c);
    logic [12:0] p;
    p = '0;
    unique case (c)
      3'd0: p = 13'h0015;
      3'd1: p = 13'h0007;
      3'd2: p = 13'h0075;
      3'd3: p = 13'h01D5;
      3'd4: p = 13'h01DD;
      3'd5: p = 13'h0757;
      3'd6: p = 13'h1DD7;
      3'd7: p = 13'h0577;
    endcase
    return p;
  endfunction

`ifdef MORSE_QUEUE_EN
  assign req_ready = !r_buf_full;
`else
  assign req_ready = (r_state == IDLE);
`endif
  assign w_accept  = req_valid && req_ready;
  assign morse_out = (r_state == SEND) && r_sh[0];
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

  always_comb begin
    w_state = r_state;
    w_sh    = r_sh;
    w_cnt   = r_cnt;
    w_gcnt  = r_gcnt;
    w_done  = 1'b0;
`ifdef MORSE_QUEUE_EN
    w_buf_code = r_buf_code;
    w_buf_full = r_buf_full;
    w_take     = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_sh    = rom(req_code);
          w_cnt   = CNT_TOP;
          w_state = SEND;
        end
      end
      SEND: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else if (r_sh[12:1] == '0) begin
          w_state = GAP;
          w_cnt   = CNT_TOP;
          w_gcnt  = GAP_TOP;
        end else begin
          w_sh  = r_sh >> 1;
          w_cnt = CNT_TOP;
        end
      end
      GAP: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else if (r_gcnt != '0) begin
          w_gcnt = r_gcnt - 1'b1;
          w_cnt  = CNT_TOP;
        end else begin
          w_done  = 1'b1;
          w_state = IDLE;
`ifdef MORSE_QUEUE_EN
          // A queued or simultaneously offered code chains with no idle cycle
          if (r_buf_full) begin
            w_sh       = rom(r_buf_code);
            w_cnt      = CNT_TOP;
            w_state    = SEND;
            w_buf_full = 1'b0;
          end else if (w_accept) begin
            w_sh    = rom(req_code);
            w_cnt   = CNT_TOP;
            w_state = SEND;
            w_take  = 1'b1;
          end
`endif
        end
      end
      default: w_state = IDLE;
    endcase
`ifdef MORSE_QUEUE_EN
    if (w_accept && (r_state != IDLE) && !w_take) begin
      w_buf_full = 1'b1;
      w_buf_code = req_code;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sh    <= w_sh;
      r_cnt   <= w_cnt;
      r_gcnt  <= w_gcnt;
      r_done  <= w_done;
    end
  end

`ifdef MORSE_QUEUE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_code <= '0;
      r_buf_full <= 1'b0;
    end else begin
      r_buf_code <= w_buf_code;
      r_buf_full <= w_buf_full;
    end
  end
`endif

endmodule
